scan_ctrl: RTL and testbench

SCAN_CTRL -- requirements
Module: scan_ctrl

---
 rtl/scan_ctrl.sv | 105 ++++++++++
 tb/tb_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/scan_ctrl.sv
// ============================================================================
//  Module      : scan_ctrl
//  Description : Full-chain scan controller for a muxed-D scan chain; shifts
//                a write word in (or recirculates) while capturing old contents.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_ctrl #(
    parameter int CHAIN_LEN = 17
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_rst,
    input  logic                 i_start,
    input  logic                 i_recirc,
    input  logic [CHAIN_LEN-1:0] i_wdata,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CHAIN_LEN-1:0] o_rdata,
    output logic                 o_chain_se,
    output logic                 o_chain_si,
    input  logic                 i_chain_so
);

    localparam int CNT_WIDTH = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_WIDTH-1:0] c_last_cnt = CNT_WIDTH'(CHAIN_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CHAIN_LEN-1:0]   r_sreg;
    logic [CHAIN_LEN-1:0]   r_rdata;
    logic                   r_mode;
    logic                   r_se;
    logic                   r_si;
    logic                   r_busy;
    logic                   r_done;

    // r_si always holds the bit for the current shift cycle; r_sreg holds the
    // remaining bits with the next one to send at its MSB.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sreg  <= '0;
            r_rdata <= '0;
            r_mode  <= 1'b0;
            r_se    <= 1'b0;
            r_si    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= SHIFT;
                        r_sreg  <= i_wdata << 1;
                        r_mode  <= i_recirc;
                        r_cnt   <= '0;
                        r_se    <= 1'b1;
                        r_si    <= ~i_recirc & i_wdata[CHAIN_LEN-1];
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_rdata <= {r_rdata[CHAIN_LEN-2:0], i_chain_so};
                    r_sreg  <= r_sreg << 1;
                    r_cnt   <= r_cnt + c_cnt_one;
                    if (r_cnt == c_last_cnt) begin
                        r_state <= DONE;
                        r_se    <= 1'b0;
                        r_si    <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_si    <= ~r_mode & r_sreg[CHAIN_LEN-1];
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Recirculation loops scan-out straight back to scan-in within the cycle.
    assign o_chain_si = r_se & (r_mode ? i_chain_so : r_si);
    assign o_chain_se = r_se;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_rdata    = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_scan_ctrl.sv
// ============================================================================
//  Module      : tb_scan_ctrl
//  Description : Directed testbench for scan_ctrl with a behavioural scan chain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_ctrl;

    localparam int CL = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          recirc;
    logic [CL-1:0] wdata;
    logic [CL-1:0] rdata;
    logic          busy;
    logic          done;
    logic          se;
    logic          si;
    logic          so;

    logic [CL-1:0] chain;
    logic [CL-1:0] load_val;
    logic          load;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [CL-1:0] preload;
        logic          recirc;
        logic [CL-1:0] wdata;
        logic [CL-1:0] exp_chain;
        logic [CL-1:0] exp_rdata;
        int            mode;      // 0 plain, 1 stray start pulses, 2 start held
    } vec_t;

    vec_t vecs [0:6];

    scan_ctrl #(.CHAIN_LEN(CL)) dut (
        .i_sys_clk  (clk),
        .i_sys_rst  (rst),
        .i_start    (start),
        .i_recirc   (recirc),
        .i_wdata    (wdata),
        .o_busy     (busy),
        .o_done     (done),
        .o_rdata    (rdata),
        .o_chain_se (se),
        .o_chain_si (si),
        .i_chain_so (so)
    );

    always #5 clk = ~clk;

    // Muxed-D chain: position CL-1 drives scan-out.
    always @(posedge clk) begin
        if (load)
            chain <= load_val;
        else if (se)
            chain <= {chain[CL-2:0], si};
    end
    assign so = chain[CL-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [CL-1:0] v);
        @(negedge clk);
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int se_cnt = 0, first_se = -1, last_se = -1;
        int done_cnt = 0, first_done = -1, last_done = -1, si_bad = 0;
        logic busy1 = 1'b0, busy19 = 1'b1;
        logic [CL-1:0] rd_done = '0;
        preload(v.preload);
        start  = 1'b1;
        recirc = v.recirc;
        wdata  = v.wdata;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (se) begin
                se_cnt++;
                if (first_se < 0) first_se = c;
                last_se = c;
            end
            if (!se && si) si_bad++;
            if (done) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = c;
                    rd_done    = rdata;
                end
                last_done = c;
            end
            if (c == 1)  busy1  = busy;
            if (c == 19) busy19 = busy;
            case (v.mode)
                1: begin
                    start = (c == 5 || c == 18);
                    if (c == 3) begin
                        wdata  = ~v.wdata;
                        recirc = ~v.recirc;
                    end
                end
                2:       start = (c <= 37);
                default: start = 1'b0;
            endcase
        end
        check({tag, " se_count"},   se_cnt,     (v.mode == 2) ? 34 : 17);
        check({tag, " first_se"},   first_se,   1);
        check({tag, " last_se"},    last_se,    (v.mode == 2) ? 36 : 17);
        check({tag, " done_count"}, done_cnt,   (v.mode == 2) ? 2 : 1);
        check({tag, " first_done"}, first_done, 18);
        check({tag, " last_done"},  last_done,  (v.mode == 2) ? 37 : 18);
        check({tag, " busy_c1"},    busy1,      1);
        check({tag, " busy_c19"},   busy19,     0);
        check({tag, " si_idle"},    si_bad,     0);
        check({tag, " rdata_done"}, rd_done,    (v.mode == 2) ? v.preload : v.exp_rdata);
        check({tag, " rdata_end"},  rdata,      v.exp_rdata);
        check({tag, " chain"},      chain,      v.exp_chain);
    endtask

    initial begin
        vecs[0] = '{17'h0_00FF, 1'b0, 17'h1_A5A5, 17'h1_A5A5, 17'h0_00FF, 0};
        vecs[1] = '{17'h1_A5A5, 1'b1, 17'h0_1234, 17'h1_A5A5, 17'h1_A5A5, 0};
        vecs[2] = '{17'h1_A5A5, 1'b0, 17'h1_FFFF, 17'h1_FFFF, 17'h1_A5A5, 0};
        vecs[3] = '{17'h1_FFFF, 1'b0, 17'h0_0000, 17'h0_0000, 17'h1_FFFF, 0};
        vecs[4] = '{17'h0_0000, 1'b1, 17'h1_FFFF, 17'h0_0000, 17'h0_0000, 0};
        vecs[5] = '{17'h0_B3C1, 1'b0, 17'h1_4E2D, 17'h1_4E2D, 17'h0_B3C1, 1};
        vecs[6] = '{17'h0_0F0F, 1'b0, 17'h1_5555, 17'h1_5555, 17'h1_5555, 2};

        rst = 1'b1; start = 1'b0; recirc = 1'b0; wdata = '0;
        load = 1'b0; load_val = '0; chain = '0;
        repeat (3) @(posedge clk);
        start = 1'b1;
        @(negedge clk);
        check("reset busy",  busy,  0);
        check("reset done",  done,  0);
        check("reset se",    se,    0);
        check("reset si",    si,    0);
        check("reset rdata", rdata, 0);
        @(posedge clk);
        @(negedge clk);
        check("reset beats start", se, 0);
        start = 1'b0;
        rst   = 1'b0;

        for (int i = 0; i < 7; i++)
            run_op(vecs[i], $sformatf("vec%0d", i));

        // Abort mid-shift: reset sampled at the end of cycle 8.
        preload(17'h1_3C3C);
        start  = 1'b1;
        recirc = 1'b0;
        wdata  = 17'h0_AAAA;
        begin
            int done_seen = 0, se_after = 0;
            for (int c = 1; c <= 30; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (c == 8) check("abort se_before", se, 1);
                if (c == 9) begin
                    check("abort se",    se,    0);
                    check("abort busy",  busy,  0);
                    check("abort rdata", rdata, 0);
                end
                if (done) done_seen++;
                if (c >= 9 && se) se_after++;
                rst = (c == 8);
            end
            check("abort no_done", done_seen, 0);
            check("abort se_quiet", se_after, 0);
        end

        run_op(vecs[0], "recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
